prime_scanner: RTL and testbench

PRIME_SCANNER -- requirements
Module: prime_scanner

---
 rtl/prime_pkg.sv | 20 ++
 rtl/prime_check.sv | 46 ++++
 rtl/prime_scanner.sv | 139 +++++++++++++
 tb/tb_prime_scanner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// -----------------------------------------------------------------------------
// prime_pkg
//   Shared definitions for the prime range scanner.
//   - WIDTH_DEFAULT : default candidate width in bits
//   - state_t       : scanner control states (IDLE / SCAN / DONE)
// -----------------------------------------------------------------------------
package prime_pkg;

  // Default candidate width; the scanner and checker both take it as their
  // parameter default so a single edit retargets the whole block.
  localparam int WIDTH_DEFAULT = 4;

  // Three-state scan controller. Encodings are fixed so waveforms are stable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : prime_pkg

// File: rtl/prime_check.sv
// -----------------------------------------------------------------------------
// prime_check
//   Purely combinational primality test of a WIDTH-bit unsigned value.
//   Ports:
//     value [WIDTH-1:0] in  : value under test
//     prime             out : 1 when value is prime (0 and 1 are not prime)
//
//   Trial division by every d in [2, 2^WIDTH-1] with d*d <= value. All loop
//   bounds are elaboration-time constants, so each iteration becomes a
//   compare against a constant divisor and the loop unrolls into plain logic.
// -----------------------------------------------------------------------------
module prime_check
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  output logic             prime
);

  localparam int NUM_VALUES = 1 << WIDTH;

  logic [31:0] value_ext_s;
  logic [31:0] div_s;
  logic        prime_s;

  // Zero-extend so all arithmetic below is done at one common width.
  assign value_ext_s = 32'(value);

  // Trial division: any divisor no larger than sqrt(value) clears the flag.
  always_comb begin
    prime_s = (value_ext_s >= 32'd2);
    div_s   = 32'd0;
    for (int d = 2; d < NUM_VALUES; d++) begin
      div_s = 32'(unsigned'(d));
      if (((div_s * div_s) <= value_ext_s) && ((value_ext_s % div_s) == 32'd0)) begin
        prime_s = 1'b0;
      end else begin
        prime_s = prime_s;
      end
    end
  end

  assign prime = prime_s;

endmodule : prime_check

// File: rtl/prime_scanner.sv
// -----------------------------------------------------------------------------
// prime_scanner
//   Walks every candidate in an inclusive range [lo, hi], one per clock,
//   counting the primes and remembering the largest one.
//
//   Ports:
//     clk                       in  : single clock, rising edge
//     rst                       in  : asynchronous, active-high reset
//     start                     in  : scan request, only looked at in IDLE
//     lo, hi        [WIDTH-1:0] in  : inclusive range, captured with start
//     cand          [WIDTH-1:0] out : candidate presented to the checker
//     cand_valid                out : cand is live (SCAN state)
//     is_prime                  out : primality of cand, forced 0 when not live
//     busy                      out : SCAN or DONE
//     done                      out : one-cycle pulse, results final
//     err                       out : range was empty (lo > hi); sticky
//     prime_count   [WIDTH:0]   out : primes found in the range
//     max_prime     [WIDTH-1:0] out : largest prime found, 0 if none
//     found                     out : prime_count != 0
//
//   Results (prime_count, max_prime, err) are registers that are only cleared
//   by an accepted start or by reset, so they stay readable in IDLE after the
//   done pulse.
// -----------------------------------------------------------------------------
module prime_scanner
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] cand,
  output logic             cand_valid,
  output logic             is_prime,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH:0]   prime_count,
  output logic [WIDTH-1:0] max_prime,
  output logic             found
);

  localparam logic [WIDTH-1:0] CAND_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CAND_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   COUNT_ZERO = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0]   COUNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH:0]   count_r;
  logic             err_r;
  logic             prime_raw_s;
  logic             live_s;

  // The checker always sees cand_r; its answer is only trusted in SCAN.
  prime_check #(
    .WIDTH (WIDTH)
  ) u_prime_check (
    .value (cand_r),
    .prime (prime_raw_s)
  );

  // Scan controller: state, candidate, captured upper bound and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cand_r  <= CAND_ZERO;
      hi_r    <= CAND_ZERO;
      max_r   <= CAND_ZERO;
      count_r <= COUNT_ZERO;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            hi_r    <= hi;
            max_r   <= CAND_ZERO;
            count_r <= COUNT_ZERO;
            if (lo <= hi) begin
              cand_r  <= lo;
              err_r   <= 1'b0;
              state_r <= SCAN;
            end else begin
              // Empty range: skip straight to the done pulse, flag it.
              err_r   <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        SCAN: begin
          if (prime_raw_s) begin
            // Candidates ascend, so the latest prime is always the largest.
            count_r <= count_r + COUNT_ONE;
            max_r   <= cand_r;
          end else begin
            count_r <= count_r;
          end
          // Terminate on equality so hi = all-ones never wraps cand to 0.
          if (cand_r == hi_r) begin
            state_r <= DONE;
          end else begin
            cand_r  <= cand_r + CAND_ONE;
            state_r <= SCAN;
          end
        end

        DONE: begin
          state_r <= IDLE;
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Status decodes depend on the state register alone.
  assign live_s      = (state_r == SCAN);
  assign cand_valid  = live_s;
  assign done        = (state_r == DONE);
  assign busy        = (state_r != IDLE);

  assign cand        = cand_r;
  assign is_prime    = live_s & prime_raw_s;
  assign err         = err_r;
  assign prime_count = count_r;
  assign max_prime   = max_r;
  assign found       = (count_r != COUNT_ZERO);

endmodule : prime_scanner

// File: tb/tb_prime_scanner.sv
// -----------------------------------------------------------------------------
// tb_prime_scanner
//   Directed bench for prime_scanner at WIDTH=4. Inputs change and outputs are
//   sampled on the falling clock edge; the DUT acts on rising edges.
// -----------------------------------------------------------------------------
module tb_prime_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] lo = 4'd0;
  logic [3:0] hi = 4'd0;
  logic [3:0] cand;
  logic       cand_valid;
  logic       is_prime;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] prime_count;
  logic [3:0] max_prime;
  logic       found;

  int total = 0;
  int bad   = 0;

  // Primes below 16: 2, 3, 5, 7, 11, 13.
  logic [15:0] prime_mask = 16'h28AC;

  prime_scanner #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lo          (lo),
    .hi          (hi),
    .cand        (cand),
    .cand_valid  (cand_valid),
    .is_prime    (is_prime),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .prime_count (prime_count),
    .max_prime   (max_prime),
    .found       (found)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_results(input string tag, input logic [4:0] ec,
                                    input logic [3:0] em, input logic ee);
    check({tag, ".done"},  32'(done), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".valid"}, 32'(cand_valid), 32'd0);
    check({tag, ".prime"}, 32'(is_prime), 32'd0);
    check({tag, ".count"}, 32'(prime_count), 32'(ec));
    check({tag, ".max"},   32'(max_prime), 32'(em));
    check({tag, ".found"}, 32'(found), 32'(ec != 5'd0));
    check({tag, ".err"},   32'(err), 32'(ee));
  endtask

  // Called on a falling edge in IDLE. Requests [l,h], scrambles lo/hi after
  // acceptance, optionally keeps start high for the whole scan, and checks
  // every candidate cycle, the done cycle and the cycle after.
  task automatic run_scan(input string tag, input logic [3:0] l, input logic [3:0] h,
                          input logic [4:0] ec, input logic [3:0] em, input logic ee,
                          input logic hold);
    lo    = l;
    hi    = h;
    start = 1'b1;
    @(negedge clk);
    lo = ~l;
    hi = ~h;
    if (!hold) start = 1'b0;
    if (l <= h) begin
      for (int i = int'(l); i <= int'(h); i++) begin
        check({tag, ".scan_valid"}, 32'(cand_valid), 32'd1);
        check({tag, ".scan_cand"},  32'(cand), 32'(i));
        check({tag, ".scan_prime"}, 32'(is_prime), 32'(prime_mask[i]));
        check({tag, ".scan_done"},  32'(done), 32'd0);
        @(negedge clk);
      end
    end
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".busy"},  32'(busy), 32'd1);
    check({tag, ".valid"}, 32'(cand_valid), 32'd0);
    check({tag, ".err"},   32'(err), 32'(ee));
    check({tag, ".count"}, 32'(prime_count), 32'(ec));
    check({tag, ".max"},   32'(max_prime), 32'(em));
    check({tag, ".found"}, 32'(found), 32'(ec != 5'd0));
    if (l <= h) check({tag, ".last_cand"}, 32'(cand), 32'(h));
    @(negedge clk);
    start = 1'b0;
    check_idle_results({tag, ".after"}, ec, em, ee);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.cand", 32'(cand), 32'd0);
    check_idle_results("rst", 5'd0, 4'd0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_results("idle0", 5'd0, 4'd0, 1'b0);

    // Full range, hi = all-ones must stop without wrapping.
    run_scan("full", 4'd0, 4'd15, 5'd6, 4'd13, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_idle_results("full.hold", 5'd6, 4'd13, 1'b0);
    check("full.hold_cand", 32'(cand), 32'd15);

    // Empty range: done and err together, no candidates.
    run_scan("empty", 4'd9, 4'd3, 5'd0, 4'd0, 1'b1, 1'b0);

    // Single prime candidate; accepted start clears err.
    run_scan("one13", 4'd13, 4'd13, 5'd1, 4'd13, 1'b0, 1'b0);

    // start held high through the scan: only one done.
    run_scan("held", 4'd2, 4'd7, 5'd4, 4'd7, 1'b0, 1'b1);
    @(negedge clk);
    check_idle_results("held.nodone", 5'd4, 4'd7, 1'b0);

    // New start clears prior results; single composite candidate.
    run_scan("one4", 4'd4, 4'd4, 5'd0, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a scan at cand = 7.
    lo    = 4'd0;
    hi    = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid.cand_before", 32'(cand), 32'd7);
    check("mid.count_before", 32'(prime_count), 32'd3);
    rst = 1'b1;
    #1;
    check("mid.cand", 32'(cand), 32'd0);
    check_idle_results("mid.rst", 5'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid.wait_done", 32'(done), 32'd0);
      check("mid.wait_busy", 32'(busy), 32'd0);
    end
    check("mid.wait_count", 32'(prime_count), 32'd0);

    // Scanner is usable again after the abort.
    run_scan("again", 4'd10, 4'd12, 5'd1, 4'd11, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prime_scanner
